rr_grant_ctrl: RTL and testbench
================================

Name: rr_grant_ctrl

Overview:
- Round-robin grant controller, directly downstream of two priority_encoder instances in the arbitration path.
- Keeps a sticky per-requester pending vector and drives two request vectors to the encoders: a masked vector (fairness window) and a full vector.
- Consumes the encoders' index/valid results and issues one registered grant at a time, using a valid/ack handshake and then a busy/done phase.

Parameters:
- OUTPUT_WIDTH, 3, index width; must equal the encoders' OUTPUT_WIDTH.
- NUM_REQ, 2**OUTPUT_WIDTH, number of requesters (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_in  in  NUM_REQ  per-requester request pulses; bit i sets pending[i]
- enc_masked_req  out  NUM_REQ  masked request vector to encoder A (bit i maps to encoder input i)
- enc_masked_idx  in  OUTPUT_WIDTH  encoder A index
- enc_masked_vld  in  1  encoder A valid
- enc_full_req  out  NUM_REQ  unmasked pending vector to encoder B
- enc_full_idx  in  OUTPUT_WIDTH  encoder B index
- enc_full_vld  in  1  encoder B valid
- grant_vld  out  1  grant offered
- grant_idx  out  OUTPUT_WIDTH  granted requester
- grant_ack  in  1  consumer accepts grant
- done  in  1  single-cycle pulse: granted transaction finished
- busy  out  1  high from ack until done
- pending  out  NUM_REQ  current pending vector

Behaviour:
- Reset (async assert, sync-style deassert use) clears: pending=0, last_grant=0, grant_vld=0, grant_idx=0, busy=0, state=IDLE.
- Encoders give highest set index priority; both paths are combinational.
- enc_full_req = pending.
- enc_masked_req[i] = pending[i] & (i < last_grant).
- Fairness: after granting g, lower indices are served next, then the search wraps to the full vector.
- Pending update every cycle: pending <= (pending & ~clr) | req_in.
  - clr is a one-hot of grant_idx, active only on the accepted-ack cycle.
  - Set wins over clear: a request on the same index in the ack cycle re-queues it.
- State IDLE:
  - If enc_masked_vld: capture enc_masked_idx.
  - Else if enc_full_vld: capture enc_full_idx.
  - On capture: grant_vld<=1, next state ISSUE.
  - Else stay in IDLE.
- State ISSUE:
  - grant_vld and grant_idx are held stable until grant_ack.
  - Pending changes during ISSUE do not alter grant_idx.
  - On grant_ack: clear pending[grant_idx], last_grant<=grant_idx, grant_vld<=0, busy<=1, next state BUSY.
- State BUSY:
  - Wait for done.
  - On done: busy<=0, next state IDLE.
  - Re-arbitration occurs in IDLE on the following cycle; there is no grant in the done cycle.
- done outside BUSY is ignored. grant_ack outside ISSUE is ignored.
- Latency:
  - req_in at cycle N: pending visible at N+1, grant_vld at N+2 (idle controller).
  - Back-to-back: done at cycle M gives the next grant_vld at M+2.
- last_grant=0 makes the masked vector empty, so the full vector is used. No special case is needed.
- An index captured from an encoder with its valid low is never used.
- All outputs are registered except enc_masked_req and enc_full_req.
- pending is registered.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2
  - NUM_REQ derivation helper
- One natural sub-module: rr_mask_gen.
  - Combinational; inputs last_grant and pending; output enc_masked_req.
- The priority_encoder instances live in the parent, not inside this block.

Test Plan:
- Reset and single request: reset_n low for 3 cycles, then req_in=8'b0000_0100 for one cycle.
  - All outputs are 0 during reset.
  - grant_vld=1 with grant_idx=2 two cycles later.
  - ack gives pending=0, busy=1; done gives busy=0.
- Round-robin order: pending=8'b1010_0101 with immediate ack/done each round.
  - Grants run 7, 5, 2, 0, then wrap to 7 when new requests are re-raised.
- Ack stall: hold grant_ack low 10 cycles while req_in sets bit 6 after a grant of idx 3 is offered.
  - grant_idx stays 3 and grant_vld stays high.
  - After ack, masked vector is below 3, so the next grant is not 6 if bits 0-2 are pending; otherwise 6.
- Set/clear collision: req_in[4] pulses in the same cycle grant_ack accepts idx 4.
  - pending[4]=1 afterward; 4 is granted again after the current BUSY phase.
- Stray handshakes: done pulse in IDLE, grant_ack in BUSY.
  - No state change and no pending change.
- Reset mid-operation: assert reset_n in ISSUE with pending=8'hFF.
  - Outputs clear asynchronously and pending=0.
  - After release, no grant until a new req_in.

Source files
------------

// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant controller slice.
// Holds the controller state encoding and the requester-count derivation.
package rr_grant_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    function automatic int num_req_of(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/rr_mask_gen.sv
// Fairness window: keeps only pending requesters below the last granted index.
// A last_grant of zero yields an empty window, which sends arbitration to the full vector.
module rr_mask_gen
    import rr_grant_ctrl_pkg::*;
#(
    parameter  int OUTPUT_WIDTH = 3,
    localparam int NUM_REQ      = num_req_of(OUTPUT_WIDTH)
) (
    input  logic [OUTPUT_WIDTH-1:0] last_grant,
    input  logic [NUM_REQ-1:0]      pending,
    output logic [NUM_REQ-1:0]      enc_masked_req
);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        assign enc_masked_req[i] = pending[i] & (OUTPUT_WIDTH'(i) < last_grant);
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller feeding two external priority encoders.
// Tracks sticky requests, picks masked-then-full, and runs a valid/ack then busy/done handshake.
module rr_grant_ctrl
    import rr_grant_ctrl_pkg::*;
#(
    parameter  int OUTPUT_WIDTH = 3,
    localparam int NUM_REQ      = num_req_of(OUTPUT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_in,
    output logic [NUM_REQ-1:0]      enc_masked_req,
    input  logic [OUTPUT_WIDTH-1:0] enc_masked_idx,
    input  logic                    enc_masked_vld,
    output logic [NUM_REQ-1:0]      enc_full_req,
    input  logic [OUTPUT_WIDTH-1:0] enc_full_idx,
    input  logic                    enc_full_vld,
    output logic                    grant_vld,
    output logic [OUTPUT_WIDTH-1:0] grant_idx,
    input  logic                    grant_ack,
    input  logic                    done,
    output logic                    busy,
    output logic [NUM_REQ-1:0]      pending
);

    state_t                  state;
    logic [OUTPUT_WIDTH-1:0] last_grant;
    logic [NUM_REQ-1:0]      clr;
    logic                    accept;

    assign accept       = (state == ISSUE) && grant_ack;
    assign enc_full_req = pending;

    rr_mask_gen #(
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_mask_gen (
        .last_grant     (last_grant),
        .pending        (pending),
        .enc_masked_req (enc_masked_req)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[grant_idx] = 1'b1;
        end
    end

    // OR-ing req_in after the clear lets a same-cycle request re-queue the index being accepted.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | req_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= '0;
            grant_vld  <= 1'b0;
            grant_idx  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_masked_vld) begin
                        grant_idx <= enc_masked_idx;
                        grant_vld <= 1'b1;
                        state     <= ISSUE;
                    end else if (enc_full_vld) begin
                        grant_idx <= enc_full_idx;
                        grant_vld <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (grant_ack) begin
                        last_grant <= grant_idx;
                        grant_vld  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant_vld <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: behavioural encoders, round-robin reference model,
// a vector table for the round-robin order, directed corner cases and randomized traffic.
module tb_rr_grant_ctrl;

    localparam int OW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req_in = '0;
    logic [NR-1:0] enc_masked_req;
    logic [OW-1:0] enc_masked_idx;
    logic          enc_masked_vld;
    logic [NR-1:0] enc_full_req;
    logic [OW-1:0] enc_full_idx;
    logic          enc_full_vld;
    logic          grant_vld;
    logic [OW-1:0] grant_idx;
    logic          grant_ack = 1'b0;
    logic          done = 1'b0;
    logic          busy;
    logic [NR-1:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference state: what the controller should hold after each edge.
    logic [NR-1:0] m_pending;
    logic [OW-1:0] m_last;
    logic [OW-1:0] m_idx;
    bit            m_vld;
    bit            m_busy;

    always #5 clk = ~clk;

    rr_grant_ctrl #(.OUTPUT_WIDTH(OW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_in         (req_in),
        .enc_masked_req (enc_masked_req),
        .enc_masked_idx (enc_masked_idx),
        .enc_masked_vld (enc_masked_vld),
        .enc_full_req   (enc_full_req),
        .enc_full_idx   (enc_full_idx),
        .enc_full_vld   (enc_full_vld),
        .grant_vld      (grant_vld),
        .grant_idx      (grant_idx),
        .grant_ack      (grant_ack),
        .done           (done),
        .busy           (busy),
        .pending        (pending)
    );

    // Highest-index-wins encoders standing in for the parent's priority_encoder instances.
    always_comb begin
        enc_masked_idx = '0;
        enc_masked_vld = 1'b0;
        enc_full_idx   = '0;
        enc_full_vld   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (enc_masked_req[i]) begin
                enc_masked_idx = OW'(i);
                enc_masked_vld = 1'b1;
            end
            if (enc_full_req[i]) begin
                enc_full_idx = OW'(i);
                enc_full_vld = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Round-robin rule: scan downward from just below the last grant, wrapping at the top.
    function automatic logic [OW-1:0] rr_pick(input logic [NR-1:0] p, input logic [OW-1:0] last);
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (int'(last) - k + NR) % NR;
            if (p[j]) return OW'(j);
        end
        return '0;
    endfunction

    function automatic logic [NR-1:0] window(input logic [NR-1:0] p, input logic [OW-1:0] last);
        return p & ((NR'(1) << last) - NR'(1));
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_last    = '0;
        m_idx     = '0;
        m_vld     = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic compare_model();
        check("pending", pending, m_pending);
        check("grant_vld", 8'(grant_vld), 8'(m_vld));
        check("grant_idx", 8'(grant_idx), 8'(m_idx));
        check("busy", 8'(busy), 8'(m_busy));
        check("enc_full_req", enc_full_req, m_pending);
        check("enc_masked_req", enc_masked_req, window(m_pending, m_last));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pending"}, pending, 8'h00);
        check({tag, "_grant_vld"}, 8'(grant_vld), 8'h00);
        check({tag, "_grant_idx"}, 8'(grant_idx), 8'h00);
        check({tag, "_busy"}, 8'(busy), 8'h00);
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic [NR-1:0] r, input logic a, input logic d);
        logic [NR-1:0] n_pending;
        req_in    = r;
        grant_ack = a;
        done      = d;
        n_pending = m_pending;
        if (m_vld && a) n_pending[m_idx] = 1'b0;
        n_pending = n_pending | r;
        if (!m_vld && !m_busy) begin
            if (m_pending != '0) begin
                m_idx = rr_pick(m_pending, m_last);
                m_vld = 1'b1;
            end
        end else if (m_vld) begin
            if (a) begin
                m_last = m_idx;
                m_vld  = 1'b0;
                m_busy = 1'b1;
            end
        end else if (d) begin
            m_busy = 1'b0;
        end
        m_pending = n_pending;
        @(posedge clk);
        #1;
        compare_model();
        req_in    = '0;
        grant_ack = 1'b0;
        done      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_in    = '0;
        grant_ack = 1'b0;
        done      = 1'b0;
        model_reset();
        #1;
        check_zero("in_reset");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic          ack;
        logic          dn;
        logic          exp_vld;
        logic [OW-1:0] exp_idx;
        logic          exp_busy;
        logic [NR-1:0] exp_pending;
    } vec_t;

    vec_t rr_tab[16];

    initial begin
        rr_tab[0]  = '{8'hA5, 0, 0, 0, 3'd0, 0, 8'hA5};
        rr_tab[1]  = '{8'h00, 0, 0, 1, 3'd7, 0, 8'hA5};
        rr_tab[2]  = '{8'h00, 1, 0, 0, 3'd7, 1, 8'h25};
        rr_tab[3]  = '{8'h00, 0, 1, 0, 3'd7, 0, 8'h25};
        rr_tab[4]  = '{8'h00, 0, 0, 1, 3'd5, 0, 8'h25};
        rr_tab[5]  = '{8'h00, 1, 0, 0, 3'd5, 1, 8'h05};
        rr_tab[6]  = '{8'h00, 0, 1, 0, 3'd5, 0, 8'h05};
        rr_tab[7]  = '{8'h00, 0, 0, 1, 3'd2, 0, 8'h05};
        rr_tab[8]  = '{8'h00, 1, 0, 0, 3'd2, 1, 8'h01};
        rr_tab[9]  = '{8'h00, 0, 1, 0, 3'd2, 0, 8'h01};
        rr_tab[10] = '{8'h00, 0, 0, 1, 3'd0, 0, 8'h01};
        rr_tab[11] = '{8'h00, 1, 0, 0, 3'd0, 1, 8'h00};
        rr_tab[12] = '{8'h80, 0, 1, 0, 3'd0, 0, 8'h80};
        rr_tab[13] = '{8'h00, 0, 0, 1, 3'd7, 0, 8'h80};
        rr_tab[14] = '{8'h00, 1, 0, 0, 3'd7, 1, 8'h00};
        rr_tab[15] = '{8'h00, 0, 1, 0, 3'd7, 0, 8'h00};

        // Reset and a single request: grant two cycles after req_in.
        do_reset();
        step(8'h04, 0, 0);
        check("single_not_yet", 8'(grant_vld), 8'h00);
        step(8'h00, 0, 0);
        check("single_vld", 8'(grant_vld), 8'h01);
        check("single_idx", 8'(grant_idx), 8'h02);
        step(8'h00, 1, 0);
        check("single_ack_pending", pending, 8'h00);
        check("single_ack_busy", 8'(busy), 8'h01);
        step(8'h00, 0, 1);
        check("single_done_busy", 8'(busy), 8'h00);

        // Round-robin order from a fresh reset.
        do_reset();
        foreach (rr_tab[i]) begin
            step(rr_tab[i].req, rr_tab[i].ack, rr_tab[i].dn);
            check($sformatf("rr%0d_vld", i), 8'(grant_vld), 8'(rr_tab[i].exp_vld));
            check($sformatf("rr%0d_idx", i), 8'(grant_idx), 8'(rr_tab[i].exp_idx));
            check($sformatf("rr%0d_busy", i), 8'(busy), 8'(rr_tab[i].exp_busy));
            check($sformatf("rr%0d_pending", i), pending, rr_tab[i].exp_pending);
        end

        // Ack stall with grant 3 held while bits 6 and 0 arrive.
        do_reset();
        step(8'h08, 0, 0);
        step(8'h00, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(k == 0 ? 8'h40 : (k == 1 ? 8'h01 : 8'h00), 0, 0);
            check("stall_vld", 8'(grant_vld), 8'h01);
            check("stall_idx", 8'(grant_idx), 8'h03);
        end
        step(8'h00, 1, 0);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0);
        check("stall_next_low", 8'(grant_idx), 8'h00);
        step(8'h00, 1, 0);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0);
        check("stall_then_6", 8'(grant_idx), 8'h06);
        step(8'h00, 1, 0);
        step(8'h00, 0, 1);

        // Set/clear collision on index 4.
        step(8'h10, 0, 0);
        step(8'h00, 0, 0);
        check("coll_offer", 8'(grant_idx), 8'h04);
        step(8'h10, 1, 0);
        check("coll_requeued", pending, 8'h10);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0);
        check("coll_regrant_vld", 8'(grant_vld), 8'h01);
        check("coll_regrant_idx", 8'(grant_idx), 8'h04);

        // Stray ack in BUSY must not clear pending[grant_idx].
        step(8'h00, 1, 0);
        step(8'h10, 0, 0);
        step(8'h00, 1, 0);
        check("stray_ack_pending", pending, 8'h10);
        check("stray_ack_busy", 8'(busy), 8'h01);
        step(8'h00, 0, 1);
        step(8'h00, 0, 0);
        step(8'h00, 1, 0);
        step(8'h00, 0, 1);
        // Stray done and ack in IDLE with nothing pending.
        step(8'h00, 0, 1);
        check("stray_done_vld", 8'(grant_vld), 8'h00);
        check("stray_done_busy", 8'(busy), 8'h00);
        step(8'h00, 1, 0);
        check("stray_idle_ack_pending", pending, 8'h00);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic [NR-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
            step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        // Reset asserted mid-ISSUE with everything pending.
        do_reset();
        step(8'hFF, 0, 0);
        step(8'h00, 0, 0);
        check("mid_in_issue", 8'(grant_vld), 8'h01);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_zero("mid_async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(8'h00, 0, 0);
            check("mid_no_grant", 8'(grant_vld), 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
